// File: rtl/div_magnitude_iterator_pkg.sv
// Shared state encoding and operand width for the multicycle divider.
package div_magnitude_iterator_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_magnitude_iterator_cla.sv
// Adder used both as a two's-complement negator and as the trial subtractor.
module cla_32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   always_comb begin
      {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
   end

endmodule

// File: rtl/div_magnitude_iterator.sv
// Operand latch, magnitude conversion and 32-step restoring divide core.
module div_magnitude_iterator
   import div_magnitude_iterator_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ctrl_DIV,
   input  logic [WIDTH-1:0]   data_operandA,
   input  logic [WIDTH-1:0]   data_operandB,
   output logic [2*WIDTH-1:0] rem_quot,
   output logic               sign_a,
   output logic               sign_b,
   output logic               busy,
   output logic               data_exception,
   output logic               data_resultRDY
);

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [2*WIDTH-1:0] rq_q, rq_d;
   logic [WIDTH-1:0]   magb_q, magb_d;
   logic               bzero_q, bzero_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic               exc_q, exc_d;

   logic [WIDTH-1:0]   neg_a, neg_b, maga, magb, diff;
   logic               a_zero, b_zero, no_borrow;

   // Carry-out of ~x+1 is set only for x==0, which flags divide-by-zero on B.
   cla_32 #(.WIDTH(WIDTH)) u_neg_a (
      .a_i(~data_operandA), .b_i('0), .cin_i(1'b1), .sum_o(neg_a), .cout_o(a_zero)
   );
   cla_32 #(.WIDTH(WIDTH)) u_neg_b (
      .a_i(~data_operandB), .b_i('0), .cin_i(1'b1), .sum_o(neg_b), .cout_o(b_zero)
   );
   cla_32 #(.WIDTH(WIDTH)) u_trial (
      .a_i(rq_q[2*WIDTH-2:WIDTH-1]), .b_i(~magb_q), .cin_i(1'b1),
      .sum_o(diff), .cout_o(no_borrow)
   );

   assign maga = (data_operandA[WIDTH-1] && !a_zero) ? neg_a : data_operandA;
   assign magb = data_operandB[WIDTH-1] ? neg_b : data_operandB;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= DIV_IDLE;
         count_q  <= '0;
         rq_q     <= '0;
         magb_q   <= '0;
         bzero_q  <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rq_q     <= rq_d;
         magb_q   <= magb_d;
         bzero_q  <= bzero_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         exc_q    <= exc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rq_d     = rq_q;
      magb_d   = magb_q;
      bzero_d  = bzero_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      exc_d    = exc_q;
      if (ctrl_DIV) begin
         state_d  = DIV_RUN;
         count_d  = '0;
         rq_d     = {{WIDTH{1'b0}}, maga};
         magb_d   = magb;
         bzero_d  = b_zero;
         sign_a_d = data_operandA[WIDTH-1];
         sign_b_d = data_operandB[WIDTH-1];
         exc_d    = 1'b0;
      end else begin
         case (state_q)
            DIV_RUN: begin
               if (bzero_q) begin
                  state_d = DIV_DONE;
                  exc_d   = 1'b1;
                  rq_d    = '0;
               end else begin
                  if (no_borrow)
                     rq_d = {diff, rq_q[WIDTH-2:0], 1'b1};
                  else
                     rq_d = {rq_q[2*WIDTH-2:0], 1'b0};
                  count_d = count_q + CNT_W'(1);
                  if (count_q == CNT_W'(WIDTH - 1))
                     state_d = DIV_DONE;
               end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
         endcase
      end
   end

   assign rem_quot       = rq_q;
   assign sign_a         = sign_a_q;
   assign sign_b         = sign_b_q;
   assign data_exception = exc_q;
   assign busy           = (state_q == DIV_RUN);
   assign data_resultRDY = (state_q == DIV_DONE);

endmodule

// File: tb/tb_div_magnitude_iterator.sv
// Directed bench with a cycle-level behavioural model of the divider front end.
module tb_div_magnitude_iterator;

   logic        clk = 1'b0;
   logic        reset;
   logic        ctrl;
   logic [31:0] opa, opb;
   logic [63:0] rq;
   logic        sa, sb, busy, exc, rdy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   div_magnitude_iterator #(.WIDTH(32), .CNT_W(6)) dut (
      .clock(clk), .reset(reset), .ctrl_DIV(ctrl),
      .data_operandA(opa), .data_operandB(opb),
      .rem_quot(rq), .sign_a(sa), .sign_b(sb), .busy(busy),
      .data_exception(exc), .data_resultRDY(rdy)
   );

   always #5 clk = ~clk;

   // Model: on start at cycle c, busy spans c+1..c+32 and ready lands at c+33
   // (c+1 and c+2 for a zero divisor); results come from plain / and %.
   bit          m_valid = 1'b0;
   int          m_bs = -1, m_be = -1, m_rdy = -1, m_from = 0;
   logic [63:0] m_rq = '0;
   logic        m_sa = 1'b0, m_sb = 1'b0, m_exc = 1'b0;

   always @(posedge clk) begin
      logic [31:0] ma, mb;
      if (reset) begin
         m_valid <= 1'b1;
         m_bs <= -1; m_be <= -1; m_rdy <= -1; m_from <= cyc + 1;
         m_rq <= '0; m_sa <= 1'b0; m_sb <= 1'b0; m_exc <= 1'b0;
      end else if (ctrl) begin
         ma = opa[31] ? 32'd0 - opa : opa;
         mb = opb[31] ? 32'd0 - opb : opb;
         m_sa <= opa[31];
         m_sb <= opb[31];
         m_bs <= cyc + 1;
         if (mb == 32'd0) begin
            m_be <= cyc + 1; m_rdy <= cyc + 2; m_from <= cyc + 2;
            m_rq <= '0; m_exc <= 1'b1;
         end else begin
            m_be <= cyc + 32; m_rdy <= cyc + 33; m_from <= cyc + 33;
            m_rq <= {ma % mb, ma / mb}; m_exc <= 1'b0;
         end
      end
      cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", 64'(busy), 64'(m_bs >= 0 && cyc >= m_bs && cyc <= m_be));
         chk("rdy", 64'(rdy), 64'(cyc == m_rdy));
         chk("sign_a", 64'(sa), 64'(m_sa));
         chk("sign_b", 64'(sb), 64'(m_sb));
         chk("exception", 64'(exc), 64'((cyc >= m_from) ? m_exc : 1'b0));
         if (cyc >= m_from) chk("rem_quot", rq, m_rq);
      end
   end

   int st;

   task automatic start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      opa = a; opb = b; ctrl = 1'b1;
      st = cyc;
      @(negedge clk);
      ctrl = 1'b0;
   endtask

   task automatic wait_rdy(output int rc);
      rc = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         #1;
         if (rdy === 1'b1) begin
            rc = cyc;
            break;
         end
      end
      chk("rdy_seen", 64'(rc >= 0), 64'd1);
   endtask

   initial begin
      int rc, st1, highs;
      reset = 1'b1; ctrl = 1'b0; opa = '0; opb = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_rq", rq, 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);

      // 1: 100/7
      start(32'd100, 32'd7);
      wait_rdy(rc);
      chk("t1_latency", 64'(rc - st), 64'd33);
      chk("t1_rq", rq, {32'd2, 32'd14});
      chk("t1_signs", {62'd0, sa, sb}, 64'd0);
      chk("t1_exc", 64'(exc), 64'd0);

      // 2: signed operands
      start(-32'sd100, 32'd7);
      wait_rdy(rc);
      chk("t2a_rq", rq, {32'd2, 32'd14});
      chk("t2a_signs", {62'd0, sa, sb}, 64'd2);
      start(-32'sd100, -32'sd7);
      wait_rdy(rc);
      chk("t2b_rq", rq, {32'd2, 32'd14});
      chk("t2b_signs", {62'd0, sa, sb}, 64'd3);

      // 3: most negative dividend, and quotient zero
      start(32'h8000_0000, 32'd1);
      wait_rdy(rc);
      chk("t3a_rq", rq, {32'd0, 32'h8000_0000});
      chk("t3a_sign_a", 64'(sa), 64'd1);
      start(32'd7, 32'd9);
      wait_rdy(rc);
      chk("t3b_rq", rq, {32'd7, 32'd0});

      // 4: divide by zero
      start(32'd5, 32'd0);
      wait_rdy(rc);
      chk("t4_latency", 64'(rc - st), 64'd2);
      chk("t4_exc", 64'(exc), 64'd1);
      chk("t4_rq", rq, 64'd0);
      chk("t4_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      #1;
      chk("t4_hold_exc", 64'(exc), 64'd1);

      // 5: restart mid-run
      start(32'd100, 32'd7);
      st1 = st;
      repeat (8) @(negedge clk);
      start(32'd9, 32'd3);
      chk("t5_restart_cycle", 64'(st - st1), 64'd10);
      wait_rdy(rc);
      chk("t5_latency", 64'(rc - st), 64'd33);
      chk("t5_rq", rq, {32'd0, 32'd3});

      // 6: reset during RUN
      start(-32'sd100, 32'd7);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6_rq", rq, 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_sign_a", 64'(sa), 64'd0);
      highs = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (rdy === 1'b1) highs++;
      end
      chk("t6_no_rdy", 64'(highs), 64'd0);
      start(32'd1000, 32'd33);
      wait_rdy(rc);
      chk("t6_recover_rq", rq, {32'd10, 32'd30});

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
